image_flow_sequencer: RTL and testbench

Top-level phase controller and single-port RAM arbiter for the image path. Owns the one address/data/write-enable port of the frame RAM and shares it between three requesters: the UART byte writer, the downsampling processor and the UART retriever. Steps the design through receive, inspect, process, inspect and transmit phases under one active-low push button. Sits between the requester blocks and the RAM, replacing the ad-hoc address mux in the top level.

---
 rtl/image_seq_pkg.sv | 17 +
 rtl/button_edge_sync.sv | 29 ++
 rtl/image_flow_sequencer.sv | 171 +++++++++++++++++
 tb/tb_image_flow_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/image_seq_pkg.sv
// rtl/image_seq_pkg.sv - image path sequencer shared types and constants
package image_seq_pkg;

  localparam int IMG_BYTES  = 262144;
  localparam int ADDR_W_DEF = $clog2(IMG_BYTES);
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_RX       = 3'd0,
    ST_VIEW_IN  = 3'd1,
    ST_PROC     = 3'd2,
    ST_VIEW_OUT = 3'd3,
    ST_TX       = 3'd4,
    ST_DONE     = 3'd5
  } seq_state_t;

endpackage

// File: rtl/button_edge_sync.sv
// rtl/button_edge_sync.sv - push button synchroniser with one-cycle falling-edge pulse
module button_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  logic sync1;
  logic sync2;
  logic prev;

  // two-flop synchroniser plus a history flop; idle level (released) is 1
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // a held button stays low, so only the high-to-low step produces a pulse
  assign press = prev & ~sync2;

endmodule

// File: rtl/image_flow_sequencer.sv
// rtl/image_flow_sequencer.sv - image path phase controller and frame RAM arbiter (option: SEQ_WATCHDOG_EN)
module image_flow_sequencer
  import image_seq_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WDOG_CYCLES = 16777216
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_n,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              wr_done,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_data,
  input  logic              proc_wen,
  input  logic              proc_done,
  input  logic [ADDR_W-1:0] tx_addr,
  input  logic              tx_done,
  output logic              proc_start,
  output logic              tx_start,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic [2:0]        phase,
  output logic              err,
  output logic              timeout
);

  seq_state_t state;
  logic       press;
  logic       wdog_hit;

  button_edge_sync u_start_btn (
    .clk   (clk),
    .reset (reset),
    .btn_n (start_n),
    .press (press)
  );

`ifdef SEQ_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              timeout_q;

  // counts cycles spent in PROC/TX; every entry comes from an idle phase, which holds it at 0
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt <= '0;
    end else if (state == ST_PROC || state == ST_TX) begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end else begin
      wdog_cnt <= '0;
    end
  end

  assign wdog_hit = (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
  assign timeout  = timeout_q;
`else
  assign wdog_hit = 1'b0;
  // WDOG_CYCLES is a positive count, so this is a constant 0 without the watchdog
  assign timeout  = (WDOG_CYCLES < 0);
`endif

  // phase FSM; start pulses are registered so they coincide with the first cycle of the new phase
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RX;
      proc_start <= 1'b0;
      tx_start   <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      proc_start <= 1'b0;
      tx_start   <= 1'b0;
      case (state)
        ST_RX: begin
          if (wr_done) state <= ST_VIEW_IN;
        end
        ST_VIEW_IN: begin
          if (press) begin
            state      <= ST_PROC;
            proc_start <= 1'b1;
          end
        end
        ST_PROC: begin
          if (proc_done) begin
            state <= ST_VIEW_OUT;
          end else if (wdog_hit) begin
            state <= ST_VIEW_OUT;
`ifdef SEQ_WATCHDOG_EN
            timeout_q <= 1'b1;
`endif
          end
        end
        ST_VIEW_OUT: begin
          if (press) begin
            state    <= ST_TX;
            tx_start <= 1'b1;
          end
        end
        ST_TX: begin
          if (tx_done) begin
            state <= ST_DONE;
          end else if (wdog_hit) begin
            state <= ST_DONE;
`ifdef SEQ_WATCHDOG_EN
            timeout_q <= 1'b1;
`endif
          end
        end
        ST_DONE: begin
          if (press) begin
            state    <= ST_TX;
            tx_start <= 1'b1;
          end
        end
        default: state <= ST_RX;
      endcase
    end
  end

  // registered RAM port mux; the owner follows the registered state, so a switch lands one cycle late
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr <= '0;
      ram_data <= '0;
      ram_wren <= 1'b0;
    end else begin
      case (state)
        ST_RX: begin
          ram_addr <= wr_addr;
          ram_data <= wr_data;
          ram_wren <= wr_en;
        end
        ST_PROC: begin
          ram_addr <= proc_addr;
          ram_data <= proc_data;
          ram_wren <= proc_wen;
        end
        ST_TX: begin
          ram_addr <= tx_addr;
          ram_data <= '0;
          ram_wren <= 1'b0;
        end
        default: begin
          ram_addr <= dbg_addr;
          ram_data <= '0;
          ram_wren <= 1'b0;
        end
      endcase
    end
  end

  // sticky flag for a write attempted by a requester that does not own the port
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if ((wr_en && state != ST_RX) || (proc_wen && state != ST_PROC)) begin
      err <= 1'b1;
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_image_flow_sequencer.sv
// tb/tb_image_flow_sequencer.sv - randomized self-checking bench for image_flow_sequencer
module tb_image_flow_sequencer;

  localparam int AW   = 18;
  localparam int DW   = 8;
  localparam int WDOG = 16;

  logic          clk = 1'b0;
  logic          reset, start_n;
  logic [AW-1:0] dbg_addr, wr_addr, proc_addr, tx_addr;
  logic [DW-1:0] wr_data, proc_data;
  logic          wr_en, wr_done, proc_wen, proc_done, tx_done;
  logic          proc_start, tx_start, ram_wren, err, timeout;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [2:0]    phase;

  image_flow_sequencer #(.ADDR_W(AW), .DATA_W(DW), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .reset(reset), .start_n(start_n), .dbg_addr(dbg_addr),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_done(wr_done),
    .proc_addr(proc_addr), .proc_data(proc_data), .proc_wen(proc_wen), .proc_done(proc_done),
    .tx_addr(tx_addr), .tx_done(tx_done), .proc_start(proc_start), .tx_start(tx_start),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .phase(phase),
    .err(err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: phase number, expected port image, and recent button samples
  int            m_phase, m_dwell;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_wren, m_ps, m_ts, m_err, m_to;
  logic          h[3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic void model_clear();
    m_phase = 0; m_dwell = 0;
    m_addr = '0; m_data = '0; m_wren = 0;
    m_ps = 0; m_ts = 0; m_err = 0; m_to = 0;
    for (int i = 0; i < 3; i++) h[i] = 1'b1;
  endfunction

  // one rising edge of the spec's behaviour, using the inputs held across that edge
  function automatic void model_edge();
    int  nxt;
    bit  btn;
    if (reset) begin
      model_clear();
      return;
    end
    case (m_phase)
      0:       begin m_addr = wr_addr;   m_data = wr_data;   m_wren = wr_en;    end
      2:       begin m_addr = proc_addr; m_data = proc_data; m_wren = proc_wen; end
      4:       begin m_addr = tx_addr;   m_data = '0;        m_wren = 1'b0;     end
      default: begin m_addr = dbg_addr;  m_data = '0;        m_wren = 1'b0;     end
    endcase
    if ((wr_en && m_phase != 0) || (proc_wen && m_phase != 2)) m_err = 1'b1;
    // a low sample taken two edges ago after a high one is a fresh press
    btn = (h[1] == 1'b0) && (h[2] == 1'b1);
    h[2] = h[1]; h[1] = h[0]; h[0] = start_n;
    m_ps = 0; m_ts = 0;
    nxt = m_phase;
    case (m_phase)
      0: if (wr_done) nxt = 1;
      1: if (btn) begin nxt = 2; m_ps = 1; end
      2: if (proc_done) nxt = 3;
      3: if (btn) begin nxt = 4; m_ts = 1; end
      4: if (tx_done) nxt = 5;
      5: if (btn) begin nxt = 4; m_ts = 1; end
      default: nxt = 0;
    endcase
`ifdef SEQ_WATCHDOG_EN
    if ((m_phase == 2 || m_phase == 4) && nxt == m_phase) begin
      m_dwell++;
      if (m_dwell == WDOG) begin
        nxt  = (m_phase == 2) ? 3 : 5;
        m_to = 1'b1;
      end
    end
`endif
    if (nxt != m_phase) m_dwell = 0;
    m_phase = nxt;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("phase",      32'(phase),      32'(m_phase));
    chk("ram_addr",   32'(ram_addr),   32'(m_addr));
    chk("ram_data",   32'(ram_data),   32'(m_data));
    chk("ram_wren",   32'(ram_wren),   32'(m_wren));
    chk("proc_start", 32'(proc_start), 32'(m_ps));
    chk("tx_start",   32'(tx_start),   32'(m_ts));
    chk("err",        32'(err),        32'(m_err));
    chk("timeout",    32'(timeout),    32'(m_to));
  endtask

  task automatic press();
    start_n = 1'b0;
    repeat (3) step();
    start_n = 1'b1;
    repeat (3) step();
  endtask

  int pulses, pulse_at, seen_done, seen_proc, hold;

  initial begin
    reset = 1; start_n = 1; dbg_addr = '0;
    wr_addr = '0; wr_data = '0; wr_en = 0; wr_done = 0;
    proc_addr = '0; proc_data = '0; proc_wen = 0; proc_done = 0;
    tx_addr = '0; tx_done = 0;
    model_clear();
    repeat (2) step();
    chk("rst_phase", 32'(phase), 0);
    chk("rst_wren", 32'(ram_wren), 0);
    reset = 0;

    // writer owns the port in RX
    wr_addr = 18'd5; wr_data = 8'hA5; wr_en = 1;
    step();
    chk("tp_wr_addr", 32'(ram_addr), 5);
    chk("tp_wr_data", 32'(ram_data), 32'hA5);
    chk("tp_wr_wren", 32'(ram_wren), 1);
    wr_en = 0;
    step();
    chk("tp_wr_off", 32'(ram_wren), 0);

    wr_done = 1; step(); wr_done = 0;
    chk("tp_view_in", 32'(phase), 1);
    dbg_addr = 18'h123; step();
    chk("tp_dbg_addr", 32'(ram_addr), 32'h123);
    proc_wen = 1; step(); proc_wen = 0; step();
    chk("tp_err", 32'(err), 1);
    chk("tp_err_nowr", 32'(ram_wren), 0);

    // long hold gives exactly one pulse on the third edge after the first low sample
    start_n = 0; pulses = 0; pulse_at = 0;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (proc_start) begin pulses++; pulse_at = i; end
    end
    start_n = 1; repeat (3) step();
    chk("tp_pulses", 32'(pulses), 1);
    chk("tp_pulse_at", 32'(pulse_at), 3);
    chk("tp_proc", 32'(phase), 2);

    proc_addr = 18'd7; proc_data = 8'h3C; proc_wen = 1; step(); proc_wen = 0;
    chk("tp_proc_addr", 32'(ram_addr), 7);
    chk("tp_proc_wren", 32'(ram_wren), 1);
    proc_done = 1; step(); proc_done = 0;
    chk("tp_view_out", 32'(phase), 3);
    press();
    chk("tp_tx", 32'(phase), 4);
    tx_addr = 18'h2AAAA; step();
    chk("tp_tx_addr", 32'(ram_addr), 32'h2AAAA);
    tx_done = 1; step(); tx_done = 0;
    chk("tp_done", 32'(phase), 5);
    press();
    chk("tp_retx", 32'(phase), 4);

    // reset in the middle of PROC with a write pending
    reset = 1; step(); reset = 0;
    wr_done = 1; step(); wr_done = 0;
    press();
    chk("tp_proc2", 32'(phase), 2);
    proc_wen = 1; reset = 1; step(); proc_wen = 0; reset = 0;
    chk("tp_rst_phase", 32'(phase), 0);
    chk("tp_rst_wren", 32'(ram_wren), 0);
    chk("tp_rst_err", 32'(err), 0);

`ifdef SEQ_WATCHDOG_EN
    wr_done = 1; step(); wr_done = 0;
    press();
    repeat (WDOG) step();
    chk("tp_wdog_phase", 32'(phase), 3);
    chk("tp_wdog_to", 32'(timeout), 1);
    reset = 1; step(); reset = 0;
`endif

    // randomized traffic against the model
    hold = 0; seen_done = 0; seen_proc = 0;
    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom_range(0, 399) == 0);
      dbg_addr  = AW'($urandom);
      wr_addr   = AW'($urandom);   wr_data   = DW'($urandom);
      proc_addr = AW'($urandom);   proc_data = DW'($urandom);
      tx_addr   = AW'($urandom);
      wr_en     = ($urandom_range(0, 7) == 0);
      proc_wen  = ($urandom_range(0, 7) == 0);
      wr_done   = ($urandom_range(0, 15) == 0);
      proc_done = ($urandom_range(0, 15) == 0);
      tx_done   = ($urandom_range(0, 15) == 0);
      if (hold > 0) begin
        start_n = 0; hold--;
      end else if (start_n == 1'b1 && $urandom_range(0, 9) == 0) begin
        start_n = 0; hold = $urandom_range(0, 6);
      end else begin
        start_n = 1;
      end
      step();
      if (phase == 3'd5) seen_done++;
      if (proc_start) seen_proc++;
    end
    chk("rand_reached_done", 32'(seen_done > 0), 1);
    chk("rand_saw_proc_start", 32'(seen_proc > 0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
